// File: rtl/vram_scheduler.sv
// VRAM port scheduler: interleaves display reads, clear-engine fills and two
// arbitrated write requesters onto one single-port framebuffer RAM.
module vram_scheduler #(
  parameter int FB_W   = 160,
  parameter int FB_H   = 120,
  parameter int PIX_W  = 8,
  parameter int ADDR_W = 15
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [9:0]        hc,
  input  logic [9:0]        vc,
  input  logic              is_blanking,
  output logic [PIX_W-1:0]  pixel_out,
  output logic              pix_valid,
  input  logic              wr0_req,
  input  logic              wr1_req,
  input  logic [ADDR_W-1:0] wr0_addr,
  input  logic [ADDR_W-1:0] wr1_addr,
  input  logic [PIX_W-1:0]  wr0_data,
  input  logic [PIX_W-1:0]  wr1_data,
  output logic              wr0_ack,
  output logic              wr1_ack,
  input  logic              clear_start,
  input  logic [PIX_W-1:0]  clear_color,
  output logic              clear_busy,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [PIX_W-1:0]  ram_wdata,
  input  logic [PIX_W-1:0]  ram_rdata
);

  localparam int FB_SIZE = FB_W * FB_H;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_SIZE - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t             state_r;
  state_t             next_state_s;
  logic [ADDR_W-1:0]  clr_addr_r;
  logic [PIX_W-1:0]   clr_color_r;
  logic               prio1_r;
  logic               rd_pend_r;
  logic               blank_d1_r;
  logic               pix_valid_r;
  logic [PIX_W-1:0]   pixel_r;
  logic               display_slot_s;
  logic [ADDR_W-1:0]  rd_addr_s;
  logic               gnt0_s;
  logic               gnt1_s;

  function automatic logic addr_in_fb(input logic [ADDR_W-1:0] a);
    return (32'(a) < 32'(FB_SIZE));
  endfunction

  assign display_slot_s = !is_blanking && (hc[1:0] == 2'b00);
  assign rd_addr_s      = ADDR_W'((32'(vc) >> 2) * 32'(FB_W) + (32'(hc) >> 2));

  assign pixel_out  = pixel_r;
  assign pix_valid  = pix_valid_r;
  assign clear_busy = (state_r == ST_CLEAR);
  assign wr0_ack    = gnt0_s;
  assign wr1_ack    = gnt1_s;

  // Clear FSM next state; the last fill happens on a free slot at LAST_ADDR
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (clear_start) next_state_s = ST_CLEAR;
        else             next_state_s = ST_IDLE;
      end
      ST_CLEAR: begin
        if (!display_slot_s && (clr_addr_r == LAST_ADDR)) next_state_s = ST_IDLE;
        else                                              next_state_s = ST_CLEAR;
      end
      default: next_state_s = ST_IDLE;
    endcase
  end

  // RAM command mux: display read > clear fill > round-robin requester write
  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = rd_addr_s;
    ram_wdata = {PIX_W{1'b0}};
    gnt0_s    = 1'b0;
    gnt1_s    = 1'b0;
    if (RESET || display_slot_s) begin
      ram_we = 1'b0;
    end else if (state_r == ST_CLEAR) begin
      ram_we    = 1'b1;
      ram_addr  = clr_addr_r;
      ram_wdata = clr_color_r;
    end else if (wr0_req && (!wr1_req || !prio1_r)) begin
      gnt0_s    = 1'b1;
      ram_addr  = wr0_addr;
      ram_wdata = wr0_data;
      ram_we    = addr_in_fb(wr0_addr);
    end else if (wr1_req) begin
      gnt1_s    = 1'b1;
      ram_addr  = wr1_addr;
      ram_wdata = wr1_data;
      ram_we    = addr_in_fb(wr1_addr);
    end else begin
      ram_we = 1'b0;
    end
  end

  // FSM state, clear counter/colour and round-robin pointer
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_r     <= ST_IDLE;
      clr_addr_r  <= {ADDR_W{1'b0}};
      clr_color_r <= {PIX_W{1'b0}};
      prio1_r     <= 1'b0;
    end else begin
      state_r <= next_state_s;
      if ((state_r == ST_IDLE) && clear_start) begin
        clr_addr_r  <= {ADDR_W{1'b0}};
        clr_color_r <= clear_color;
      end else if ((state_r == ST_CLEAR) && !display_slot_s) begin
        clr_addr_r <= clr_addr_r + ADDR_ONE;
      end
      if (gnt0_s)      prio1_r <= 1'b1;
      else if (gnt1_s) prio1_r <= 1'b0;
    end
  end

  // Display pipeline: data returns one cycle after the slot, latched on the next edge
  always_ff @(posedge CLK) begin
    if (RESET) begin
      rd_pend_r   <= 1'b0;
      blank_d1_r  <= 1'b1;
      pix_valid_r <= 1'b0;
      pixel_r     <= {PIX_W{1'b0}};
    end else begin
      rd_pend_r   <= display_slot_s;
      blank_d1_r  <= is_blanking;
      pix_valid_r <= !blank_d1_r;
      if (blank_d1_r)     pixel_r <= {PIX_W{1'b0}};
      else if (rd_pend_r) pixel_r <= ram_rdata;
    end
  end

endmodule

// File: tb/tb_vram_scheduler.sv
// Randomised scoreboard bench for vram_scheduler with a frame-level reference
// model of VRAM contents, display pixels, clear progress and arbitration.
module tb_vram_scheduler;
  localparam int FB_W    = 160;
  localparam int FB_H    = 120;
  localparam int PIX_W   = 8;
  localparam int ADDR_W  = 15;
  localparam int FB_SIZE = FB_W * FB_H;

  logic              CLK = 1'b0;
  logic              RESET = 1'b1;
  logic [9:0]        hc = 10'd0;
  logic [9:0]        vc = 10'd500;
  logic              is_blanking = 1'b1;
  logic [PIX_W-1:0]  pixel_out;
  logic              pix_valid;
  logic              wr0_req = 1'b0, wr1_req = 1'b0;
  logic [ADDR_W-1:0] wr0_addr = '0, wr1_addr = '0;
  logic [PIX_W-1:0]  wr0_data = '0, wr1_data = '0;
  logic              wr0_ack, wr1_ack;
  logic              clear_start = 1'b0;
  logic [PIX_W-1:0]  clear_color = '0;
  logic              clear_busy;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [PIX_W-1:0]  ram_wdata;
  logic [PIX_W-1:0]  ram_rdata = '0;

  vram_scheduler #(.FB_W(FB_W), .FB_H(FB_H), .PIX_W(PIX_W), .ADDR_W(ADDR_W)) dut (
    .CLK(CLK), .RESET(RESET), .hc(hc), .vc(vc), .is_blanking(is_blanking),
    .pixel_out(pixel_out), .pix_valid(pix_valid),
    .wr0_req(wr0_req), .wr1_req(wr1_req), .wr0_addr(wr0_addr), .wr1_addr(wr1_addr),
    .wr0_data(wr0_data), .wr1_data(wr1_data), .wr0_ack(wr0_ack), .wr1_ack(wr1_ack),
    .clear_start(clear_start), .clear_color(clear_color), .clear_busy(clear_busy),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #20 CLK = ~CLK;

  // Single-port VRAM with one-cycle read latency
  logic [PIX_W-1:0] mem [0:32767];
  always @(posedge CLK) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  typedef struct { logic [ADDR_W-1:0] addr; logic [PIX_W-1:0] data; } wr_t;
  typedef struct { logic v; logic [PIX_W-1:0] p; } px_t;

  logic [PIX_W-1:0] ref_mem [0:FB_SIZE-1];
  wr_t wq0[$];
  wr_t wq1[$];
  px_t pq[$];
  int  checks = 0;
  int  errors = 0;
  bit  ack0_seen = 1'b0, ack1_seen = 1'b0;
  bit  directed = 1'b0;
  logic [PIX_W-1:0] cur_pix = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic wr_t make_req();
    wr_t r;
    if ($urandom_range(0, 7) == 0) r.addr = ADDR_W'(FB_SIZE + $urandom_range(0, 3));
    else                           r.addr = ADDR_W'($urandom_range(0, FB_SIZE - 1));
    r.data = PIX_W'($urandom);
    return r;
  endfunction

  task automatic drive_reqs(input int pct);
    wr_t r;
    if (ack0_seen) begin wr0_req = 1'b0; ack0_seen = 1'b0; end
    if (ack1_seen) begin wr1_req = 1'b0; ack1_seen = 1'b0; end
    if (!wr0_req && ($urandom_range(0, 99) < pct)) begin
      r = make_req(); wq0.push_back(r);
      wr0_req = 1'b1; wr0_addr = r.addr; wr0_data = r.data;
    end
    if (!wr1_req && ($urandom_range(0, 99) < pct)) begin
      r = make_req(); wq1.push_back(r);
      wr1_req = 1'b1; wr1_addr = r.addr; wr1_data = r.data;
    end
  endtask

  // One 800-clock scan line at vertical position v
  task automatic run_line(input int v, input int pct, input int clr_at, input logic [7:0] clr_col,
                          input int rst_lo, input int rst_hi);
    px_t e;
    for (int h = 0; h < 800; h++) begin
      @(posedge CLK); #1;
      hc = 10'(h);
      vc = 10'(v);
      is_blanking = (h >= 640) || (v >= 480);
      RESET = (h >= rst_lo) && (h < rst_hi);
      clear_start = (h == clr_at);
      clear_color = (h == clr_at) ? clr_col : PIX_W'($urandom);
      drive_reqs(pct);
      if (!RESET) begin
        if (!is_blanking) begin
          if (h % 4 == 0) cur_pix = ref_mem[(v / 4) * FB_W + h / 4];
          e.v = 1'b1; e.p = cur_pix;
        end else begin
          e.v = 1'b0; e.p = '0;
        end
        pq.push_back(e);
      end
    end
  endtask

  // Monitor / scoreboard state
  bit               clr_act = 1'b0;
  int               clr_nxt = 0;
  logic [PIX_W-1:0] clr_col_m = '0;
  int               last_w = 1;
  bit               rst_prev = 1'b0;

  // Per-cycle comparison of every DUT output against the reference model
  always @(negedge CLK) begin
    bit  slot, act_now, ok;
    int  w;
    px_t px;
    wr_t e;
    slot = !is_blanking && (hc[1:0] == 2'b00);
    if (RESET) begin
      chk("rst_we", 32'(ram_we), 32'd0);
      chk("rst_acks", 32'({wr0_ack, wr1_ack}), 32'd0);
      if (rst_prev) begin
        chk("rst_busy", 32'(clear_busy), 32'd0);
        chk("rst_pix_valid", 32'(pix_valid), 32'd0);
        chk("rst_pixel", 32'(pixel_out), 32'd0);
      end
      clr_act = 1'b0;
      last_w = 1;
      pq.delete();
      rst_prev = 1'b1;
    end else begin
      rst_prev = 1'b0;
      act_now = clr_act;
      if (pq.size() == 3) begin
        px = pq.pop_front();
        chk("pix_valid", 32'(pix_valid), 32'(px.v));
        chk("pixel", 32'(pixel_out), 32'(px.p));
      end
      if (directed && (vc == 10'd4) && (hc == 10'd8)) chk("req036_addr", 32'(ram_addr), 32'd162);
      if (directed && (vc == 10'd4) && (hc >= 10'd10) && (hc <= 10'd13)) begin
        chk("req036_pix", 32'(pixel_out), 32'h5A);
        chk("req036_valid", 32'(pix_valid), 32'd1);
      end
      chk("clear_busy", 32'(clear_busy), 32'(act_now));
      if (slot) begin
        chk("slot_we", 32'(ram_we), 32'd0);
        chk("slot_addr", 32'(ram_addr), 32'((int'(vc) >> 2) * FB_W + (int'(hc) >> 2)));
        chk("slot_acks", 32'({wr0_ack, wr1_ack}), 32'd0);
      end else if (act_now) begin
        chk("clr_we", 32'(ram_we), 32'd1);
        chk("clr_addr", 32'(ram_addr), 32'(clr_nxt));
        chk("clr_data", 32'(ram_wdata), 32'(clr_col_m));
        chk("clr_acks", 32'({wr0_ack, wr1_ack}), 32'd0);
        ref_mem[clr_nxt] = clr_col_m;
        clr_nxt++;
        if (clr_nxt == FB_SIZE) clr_act = 1'b0;
      end else begin
        w = -1;
        if (wr0_req && wr1_req) w = (last_w == 0) ? 1 : 0;
        else if (wr0_req)       w = 0;
        else if (wr1_req)       w = 1;
        chk("acks", 32'({wr0_ack, wr1_ack}), (w == 0) ? 32'd2 : (w == 1) ? 32'd1 : 32'd0);
        if (w >= 0) begin
          ok = (w == 0) ? (wq0.size() > 0) : (wq1.size() > 0);
          if (!ok) begin
            checks++; errors++;
            $display("FAIL wr_queue: requester %0d granted with no pending write", w);
          end else begin
            e = (w == 0) ? wq0.pop_front() : wq1.pop_front();
            chk("wr_addr", 32'(ram_addr), 32'(e.addr));
            chk("wr_we", 32'(ram_we), 32'(int'(e.addr) < FB_SIZE));
            if (int'(e.addr) < FB_SIZE) begin
              chk("wr_data", 32'(ram_wdata), 32'(e.data));
              ref_mem[e.addr] = e.data;
            end
          end
          last_w = w;
          if (w == 0) ack0_seen = 1'b1;
          else        ack1_seen = 1'b1;
        end
      end
      if (clear_start && !act_now) begin
        clr_act = 1'b1;
        clr_nxt = 0;
        clr_col_m = clear_color;
      end
    end
  end

  initial begin
    logic [PIX_W-1:0] v;
    for (int i = 0; i < 32768; i++) begin
      v = PIX_W'($urandom);
      mem[i] = v;
      if (i < FB_SIZE) ref_mem[i] = v;
    end
    mem[162] = 8'h5A;
    ref_mem[162] = 8'h5A;

    run_line(500, 0, -1, 8'h00, 0, 4);
    directed = 1'b1;
    run_line(4, 0, -1, 8'h00, -1, -1);
    directed = 1'b0;
    run_line(5, 60, -1, 8'h00, -1, -1);
    run_line(510, 100, -1, 8'h00, -1, -1);
    for (int k = 0; k < 4; k++) run_line($urandom_range(0, 479), 50, -1, 8'h00, -1, -1);
    run_line(490, 50, 10, 8'h1C, -1, -1);
    run_line(491, 50, 300, 8'hE3, -1, -1);
    for (int k = 0; k < 24; k++) run_line(492 + k, 50, -1, 8'h00, -1, -1);
    for (int k = 0; k < 3; k++) run_line($urandom_range(0, 479), 30, -1, 8'h00, -1, -1);
    run_line(520, 50, 10, 8'h33, 400, 404);
    run_line(521, 100, -1, 8'h00, -1, -1);
    for (int k = 0; k < 2; k++) run_line($urandom_range(0, 479), 50, -1, 8'h00, -1, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/vram_scheduler.md
VRAM_SCHEDULER -- requirements
Module: vram_scheduler

Interface
REQ-001 Parameter FB_W, default 160: framebuffer width in pixels (each drives 4x4 screen pixels).
REQ-002 Parameter FB_H, default 120: framebuffer height in pixels.
REQ-003 Parameter PIX_W, default 8: pixel width in bits (RGB332).
REQ-004 Parameter ADDR_W, default 15: framebuffer word address width.
REQ-005 CLK  in  1: single 25.175 MHz clock; all state changes on posedge CLK.
REQ-006 RESET  in  1: reset, synchronous and active-high.
REQ-007 hc, vc  in  10 each: horizontal and vertical timing counters from the VGA timing generator.
REQ-008 is_blanking  in  1: high outside the 640x480 visible area.
REQ-009 pixel_out  out  PIX_W: registered display pixel.
REQ-010 pix_valid  out  1: registered; high when pixel_out belongs to the visible area.
REQ-011 wr0_req, wr1_req  in  1 each: write requests from requesters 0 and 1.
REQ-012 wr0_addr, wr1_addr  in  ADDR_W each; wr0_data, wr1_data  in  PIX_W each: write address and data.
REQ-013 wr0_ack, wr1_ack  out  1 each: write accepted this cycle.
REQ-014 clear_start  in  1: pulse that starts a full-framebuffer clear; clear_color  in  PIX_W: the fill value.
REQ-015 clear_busy  out  1: high while the clear engine runs.
REQ-016 ram_addr  out  ADDR_W; ram_we  out  1; ram_wdata  out  PIX_W: single-port VRAM command, combinational from current state.
REQ-017 ram_rdata  in  PIX_W: VRAM read data, valid exactly 1 cycle after the read command.

Function
REQ-018 Display slot: cycle with is_blanking=0 and hc[1:0]=0; ram_we=0, ram_addr=(vc>>2)*FB_W+(hc>>2).
REQ-019 Display slot has absolute priority; no write is issued or acked in it.
REQ-020 pixel_out latches ram_rdata on the edge 1 cycle after the display slot, i.e. valid during hc=4k+2..4k+5 for slot hc=4k (2-cycle lag).
REQ-021 pix_valid equals ~is_blanking delayed 2 cycles; pixel_out forced 0 whenever delayed blanking is high.
REQ-022 Free slot: every non-display cycle, including all blanking cycles.
REQ-023 FSM states IDLE and CLEAR; IDLE->CLEAR on clear_start; CLEAR->IDLE after word FB_W*FB_H-1 is written.
REQ-024 clear_start while in CLEAR is ignored; clear_color is sampled only on the accepted start.
REQ-025 In CLEAR, every free slot writes clear_color to the clear counter address, which starts at 0 and increments per write; requesters receive no ack.
REQ-026 clear_busy is high from the cycle after the accepted clear_start through the cycle of the last clear write.
REQ-027 In IDLE, a free slot serves one requester; if only one requests it wins; if both request, round-robin picks the one not granted last.
REQ-028 Grant: ram_we=1, ram_addr/ram_wdata from the winner, winner's ack high that same cycle, combinationally.
REQ-029 Requester holds req/addr/data stable until ack; req high after ack means a new write.
REQ-030 Requester address >= FB_W*FB_H: acked normally, ram_we held 0, round-robin pointer still updated.
REQ-031 Round-robin pointer updates only on a grant.
REQ-032 Read/write address arithmetic uses at least ADDR_W bits; no wrap within valid range.

Reset
REQ-033 RESET high at a posedge: pixel_out=0, pix_valid=0, FSM=IDLE, clear counter=0, clear_busy=0, round-robin favours wr0 next.
REQ-034 While RESET is high, ram_we=0 and wr0_ack=wr1_ack=0.
REQ-035 RESET during CLEAR aborts the clear; partially cleared contents are not restored.

Verification
REQ-036 Visible hc=8, vc=4, word 162=0x5A -> ram_addr=162 at hc=8; pixel_out=0x5A, pix_valid=1 during hc=10..13.
REQ-037 wr0 and wr1 held requesting through blanking -> acks alternate wr0, wr1, wr0, ... one per cycle; never both in one cycle.
REQ-038 wr0 requests during visible line -> no ack when hc[1:0]=0; ack in the next free cycle.
REQ-039 clear_start with clear_color=0x1C -> all 19200 words written 0x1C; no requester acks meanwhile; clear_busy falls after address 19199.
REQ-040 wr1_addr=19200 -> wr1_ack=1, ram_we=0; RESET mid-clear -> clear_busy=0 next cycle, ram_we=0 while RESET high.
